// File: rtl/memory_pkg.sv
// Shared memory-port types, widths and the size/alignment rule.
package memory_pkg;

  localparam int unsigned MEM_ADDR_WIDTH = 16;
  localparam int unsigned MEM_WORD_WIDTH = 32;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10,
    MEM_RSVD = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'b00,
    ARB_ISSUE = 2'b01,
    ARB_WAIT  = 2'b10,
    ARB_RESP  = 2'b11
  } arb_state_e;

  // Transaction captured at grant time: who owns it, direction, check result
  typedef struct packed {
    logic owner_ls;
    logic we;
    logic ok;
  } arb_txn_t;

  // Legal access: any byte, even-address half, word-aligned word; reserved size never
  function automatic logic mem_aligned(input mem_size_e mem_size, input logic [1:0] addr_lsbs);
    logic ok;
    ok = 1'b0;
    case (mem_size)
      MEM_BYTE: ok = 1'b1;
      MEM_HALF: ok = ~addr_lsbs[0];
      MEM_WORD: ok = (addr_lsbs == 2'b00);
      default:  ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_align_check.sv
// Combinational size/alignment check for the request being granted.
module mem_align_check
  import memory_pkg::*;
(
  input  mem_size_e  mem_size,
  input  logic [1:0] addr_lsbs,
  output logic       aligned_c
);

  // Pass/fail of the candidate access
  always_comb begin
    aligned_c = mem_aligned(mem_size, addr_lsbs);
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF (read-only) and LS (read/write) onto one memory read and one
// write port, one transaction in flight, LS priority with an IF starvation cap.
module mem_port_arbiter
  import memory_pkg::*;
#(
  parameter int unsigned RD_LATENCY    = 1,
  parameter int unsigned MAX_LS_STREAK = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      IF_REQ,
  input  logic [MEM_ADDR_WIDTH-1:0] IF_ADDR,
  output logic                      IF_GNT,
  output logic                      IF_RVALID,
  output logic [MEM_WORD_WIDTH-1:0] IF_RDATA,
  output logic                      IF_ERR,
  input  logic                      LS_REQ,
  input  logic                      LS_WE,
  input  logic [1:0]                LS_WORD,
  input  logic [MEM_ADDR_WIDTH-1:0] LS_ADDR,
  input  logic [MEM_WORD_WIDTH-1:0] LS_WDATA,
  output logic                      LS_GNT,
  output logic                      LS_RVALID,
  output logic [MEM_WORD_WIDTH-1:0] LS_RDATA,
  output logic                      LS_ERR,
  output logic                      RD_ENABLE,
  output logic [1:0]                RD_WORD,
  output logic [MEM_ADDR_WIDTH-1:0] RD_ADDR,
  input  logic [MEM_WORD_WIDTH-1:0] RD_DATA,
  input  logic                      RD_ADDR_ERR,
  output logic                      WR_ENABLE,
  output logic [1:0]                WR_WORD,
  output logic [MEM_ADDR_WIDTH-1:0] WR_ADDR,
  output logic [MEM_WORD_WIDTH-1:0] WR_DATA,
  input  logic                      WR_ADDR_ERR
);

  localparam int unsigned AW       = MEM_ADDR_WIDTH;
  localparam int unsigned DW       = MEM_WORD_WIDTH;
  localparam int unsigned LAT_W    = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam int unsigned STREAK_W = $clog2(MAX_LS_STREAK + 1);

  arb_state_e          state, state_nxt;
  arb_txn_t            txn;
  logic [LAT_W-1:0]    lat_cnt;
  logic [STREAK_W-1:0] streak;

  logic          arb_window_c, streak_full_c, pick_ls_c, pick_if_c, grant_c, we_sel_c;
  logic          aligned_c, issue_rd_c, issue_wr_c, rsp_load_c, rsp_err_c;
  mem_size_e     size_sel_c;
  logic [AW-1:0] addr_sel_c;
  logic [DW-1:0] rsp_data_c;

  mem_align_check u_align (
    .mem_size  (size_sel_c),
    .addr_lsbs (addr_sel_c[1:0]),
    .aligned_c (aligned_c)
  );

  assign IF_GNT = pick_if_c;
  assign LS_GNT = pick_ls_c;

  // Arbitration: LS wins unless IF has been passed over MAX_LS_STREAK times
  always_comb begin
    arb_window_c  = ~RST && ((state == ARB_IDLE) || (state == ARB_RESP));
    streak_full_c = (streak == STREAK_W'(MAX_LS_STREAK));
    pick_ls_c     = arb_window_c && LS_REQ && !(IF_REQ && streak_full_c);
    pick_if_c     = arb_window_c && IF_REQ && !pick_ls_c;
    grant_c       = pick_ls_c || pick_if_c;
    we_sel_c      = pick_ls_c && LS_WE;
    size_sel_c    = pick_ls_c ? mem_size_e'(LS_WORD) : MEM_WORD;
    addr_sel_c    = pick_ls_c ? LS_ADDR : IF_ADDR;
  end

  // Next state; rsp_load_c marks the cycle whose end loads the response
  always_comb begin
    state_nxt  = state;
    rsp_load_c = 1'b0;
    case (state)
      ARB_IDLE: if (grant_c) state_nxt = ARB_ISSUE;
      ARB_ISSUE: begin
        if (txn.we || !txn.ok) begin
          state_nxt  = ARB_RESP;
          rsp_load_c = 1'b1;
        end else begin
          state_nxt = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        if (lat_cnt == LAT_W'(RD_LATENCY - 1)) begin
          state_nxt  = ARB_RESP;
          rsp_load_c = 1'b1;
        end
      end
      ARB_RESP: state_nxt = grant_c ? ARB_ISSUE : ARB_IDLE;
      default:  state_nxt = ARB_IDLE;
    endcase
  end

  // Memory strobes for the granted access and the response value to capture
  always_comb begin
    issue_rd_c = grant_c && aligned_c && !we_sel_c;
    issue_wr_c = grant_c && aligned_c && we_sel_c;
    rsp_data_c = '0;
    rsp_err_c  = 1'b0;
    if (state == ARB_WAIT) begin
      rsp_data_c = RD_DATA;
      rsp_err_c  = RD_ADDR_ERR;
    end else begin
      rsp_err_c = !txn.ok || WR_ADDR_ERR;
    end
  end

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= ARB_IDLE;
    else     state <= state_nxt;
  end

  // Captured transaction, read latency counter and LS streak counter
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      txn     <= '0;
      lat_cnt <= '0;
      streak  <= '0;
    end else begin
      if (grant_c) txn <= '{owner_ls: pick_ls_c, we: we_sel_c, ok: aligned_c};
      if (state == ARB_ISSUE)     lat_cnt <= '0;
      else if (state == ARB_WAIT) lat_cnt <= lat_cnt + LAT_W'(1);
      if (pick_if_c || (arb_window_c && !IF_REQ)) streak <= '0;
      else if (pick_ls_c && IF_REQ && !streak_full_c) streak <= streak + STREAK_W'(1);
    end
  end

  // Memory port outputs: high only during the ISSUE cycle
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      RD_ENABLE <= 1'b0;
      RD_WORD   <= 2'b00;
      RD_ADDR   <= '0;
      WR_ENABLE <= 1'b0;
      WR_WORD   <= 2'b00;
      WR_ADDR   <= '0;
      WR_DATA   <= '0;
    end else begin
      RD_ENABLE <= issue_rd_c;
      RD_WORD   <= issue_rd_c ? 2'(size_sel_c) : 2'b00;
      RD_ADDR   <= issue_rd_c ? addr_sel_c : '0;
      WR_ENABLE <= issue_wr_c;
      WR_WORD   <= issue_wr_c ? 2'(size_sel_c) : 2'b00;
      WR_ADDR   <= issue_wr_c ? addr_sel_c : '0;
      WR_DATA   <= issue_wr_c ? LS_WDATA : '0;
    end
  end

  // Response registers: one-cycle strobe to the owner, data/error held
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      IF_RVALID <= 1'b0;
      IF_RDATA  <= '0;
      IF_ERR    <= 1'b0;
      LS_RVALID <= 1'b0;
      LS_RDATA  <= '0;
      LS_ERR    <= 1'b0;
    end else begin
      IF_RVALID <= rsp_load_c && !txn.owner_ls;
      LS_RVALID <= rsp_load_c && txn.owner_ls;
      if (rsp_load_c && txn.owner_ls) begin
        LS_RDATA <= rsp_data_c;
        LS_ERR   <= rsp_err_c;
      end
      if (rsp_load_c && !txn.owner_ls) begin
        IF_RDATA <= rsp_data_c;
        IF_ERR   <= rsp_err_c;
      end
    end
  end

endmodule
